uiarp_sched: RTL
================

UIARP_SCHED -- requirements
Module: uiarp_sched

Interface
REQ-001 SHALL have parameter RETRY_CYCLES, default 125000000, meaning cycles waited for an ARP reply after each request transmission (1 s at 125 MHz).
REQ-002 SHALL have parameter MAX_RETRY, default 3, meaning request retransmissions after the first before the query fails.
REQ-003 SHALL have port I_arp_clk  input  1  the single clock.
REQ-004 SHALL have port I_arp_reset  input  1  reset, synchronous to I_arp_clk, active-high.
REQ-005 SHALL have port I_ip_local_addr  input  32  local IP; stable during operation.
REQ-006 SHALL have ports I_arp_req_valid, I_arp_req_ip_addr, I_arp_req_mac_addr  input  1/32/48  one-cycle pulse from the ARP receiver when a peer requests our MAC, with peer IP/MAC.
REQ-007 SHALL have ports I_arp_reply_done, I_arp_reply_ip_addr, I_arp_reply_mac_addr  input  1/32/48  one-cycle pulse from the ARP receiver on any received ARP reply, with sender IP/MAC.
REQ-008 SHALL have ports I_resolve_req, I_resolve_ip_addr  input  1/32  one-cycle request from the UDP/IP TX path to resolve an IP.
REQ-009 SHALL have ports O_resolve_busy, O_resolve_done, O_resolve_fail, O_resolve_mac_addr  output  1/1/1/48  query in progress; success pulse; failure pulse; resolved MAC.
REQ-010 SHALL have ports O_tx_valid, O_tx_oper, O_tx_ip_addr, O_tx_mac_addr  output  1/16/32/48  frame command to the ARP transmitter; O_tx_oper is 0x0001 (request) or 0x0002 (reply).
REQ-011 SHALL have ports I_tx_ready, I_tx_done  input  1/1  transmitter accepts the command; transmitter finished the frame (one-cycle pulse).

Function
REQ-012 SHALL hold one pending-reply slot; I_arp_req_valid loads it (IP, MAC) and sets the pending flag; a new pulse while pending overwrites the slot (latest wins).
REQ-013 SHALL hold one query slot; I_resolve_req is accepted only when O_resolve_busy=0, sets busy the next cycle, latches the IP, clears the retry count and marks a request send as needed; it is ignored while busy.
REQ-014 SHALL run a TX FSM with states IDLE, CMD, WAIT_DONE.
REQ-015 IDLE: if reply pending -> CMD with oper 0x0002, slot IP/MAC, and clear the pending flag; else if a request send is needed -> CMD with oper 0x0001, query IP, MAC 48'h0, and clear the need flag; reply has strict priority.
REQ-016 CMD: O_tx_valid=1, fields held stable; advance to WAIT_DONE in the cycle I_tx_ready=1.
REQ-017 WAIT_DONE: on I_tx_done -> IDLE; if the frame was a request and the query is still busy, start the retry timer at 0.
REQ-018 The retry timer SHALL count only while busy, running and no request is queued or in flight; on reaching RETRY_CYCLES-1: if retry count < MAX_RETRY, increment the count and set send-needed; else pulse O_resolve_fail for one cycle and clear busy.
REQ-019 When busy, an I_arp_reply_done whose IP equals the query IP SHALL pulse O_resolve_done one cycle later with O_resolve_mac_addr=reply MAC, clear busy and stop the timer; non-matching replies are ignored.
REQ-020 A match in the same cycle as timer expiry SHALL win (done, no fail, no retry).
REQ-021 A match while the query's own request is in CMD or WAIT_DONE SHALL complete the query; the in-flight command still finishes its handshake and no timer starts.
REQ-022 O_resolve_mac_addr SHALL hold its last value until the next success.
REQ-023 The first I_resolve_req SHALL produce O_tx_valid within 2 cycles when the FSM is IDLE and no reply is pending.

Reset
REQ-024 While I_arp_reset=1 at a clock edge, all outputs SHALL be 0 (O_tx_oper 16'h0000, addresses 0), the FSM SHALL be IDLE, and the pending flag, query busy, timer and retry count SHALL be cleared; an in-flight command is abandoned.

Structure
REQ-025 Package uiarp_pkg SHALL hold ARP_REQUEST=16'h0001, ARP_REPLY=16'h0002 and the TX FSM state encoding.
REQ-026 The retry timer with its compare and expiry pulse SHALL be sub-module uiarp_retry_timer (start, clear, enable, expire).

Verification (RETRY_CYCLES=20, MAX_RETRY=2, I_tx_ready=1, I_tx_done 5 cycles after accept)
REQ-027 Resolve IP 192.168.1.10 -> one request command; reply from .10 with MAC 00:0a:35:01:02:03 at cycle 12 -> O_resolve_done with that MAC, busy=0, no further command.
REQ-028 Resolve with no replies -> exactly 3 request commands about 25 cycles apart, then one O_resolve_fail pulse, busy=0.
REQ-029 I_arp_req_valid and I_resolve_req in the same cycle -> reply command (0x0002, peer IP/MAC) is issued first, then the request command.
REQ-030 Reply from a non-matching IP, then a matching reply in the same cycle as timer expiry -> only O_resolve_done, no fail, no extra request.
REQ-031 Two I_arp_req_valid pulses while I_tx_ready=0 -> the second peer's reply is sent once; the first is dropped.
REQ-032 Reset asserted in WAIT_DONE with a query busy -> all outputs 0 next cycle; a new resolve after reset behaves as in REQ-027.

Source files
------------

// File: rtl/uiarp_pkg.sv
// Shared constants and TX state encoding for the ARP request/reply scheduler.
package uiarp_pkg;
   localparam logic [15:0] ARP_REQUEST = 16'h0001;
   localparam logic [15:0] ARP_REPLY   = 16'h0002;

   typedef enum logic [1:0] {
      TX_IDLE      = 2'd0,
      TX_CMD       = 2'd1,
      TX_WAIT_DONE = 2'd2
   } tx_state_e;
endpackage

// File: rtl/uiarp_retry_timer.sv
// Reply wait timer: restarts from zero on start, counts while enabled,
// pulses expire combinationally on its last count and then stops itself.
module uiarp_retry_timer #(
   parameter int unsigned CYCLES = 125000000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic start_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);
   localparam int unsigned   CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_q, run_d;

   assign expire_o = run_q & enable_i & (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      run_d = run_q;
      if (clear_i) begin
         run_d = 1'b0;
      end else if (start_i) begin
         run_d = 1'b1;
         cnt_d = '0;
      end else if (expire_o) begin
         run_d = 1'b0;
      end else if (run_q && enable_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end
endmodule

// File: rtl/uiarp_sched.sv
// ARP scheduler: queues replies to peer requests and runs one outstanding
// IP resolve query with timed retransmission, feeding a single ARP transmitter.
module uiarp_sched
   import uiarp_pkg::*;
#(
   parameter int unsigned RETRY_CYCLES = 125000000,
   parameter int unsigned MAX_RETRY    = 3
) (
   input  logic        I_arp_clk,
   input  logic        I_arp_reset,
   input  logic [31:0] I_ip_local_addr,
   input  logic        I_arp_req_valid,
   input  logic [31:0] I_arp_req_ip_addr,
   input  logic [47:0] I_arp_req_mac_addr,
   input  logic        I_arp_reply_done,
   input  logic [31:0] I_arp_reply_ip_addr,
   input  logic [47:0] I_arp_reply_mac_addr,
   input  logic        I_resolve_req,
   input  logic [31:0] I_resolve_ip_addr,
   output logic        O_resolve_busy,
   output logic        O_resolve_done,
   output logic        O_resolve_fail,
   output logic [47:0] O_resolve_mac_addr,
   output logic        O_tx_valid,
   output logic [15:0] O_tx_oper,
   output logic [31:0] O_tx_ip_addr,
   output logic [47:0] O_tx_mac_addr,
   input  logic        I_tx_ready,
   input  logic        I_tx_done
);
   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   tx_state_e     state_q, state_d;
   logic          take_reply, take_req, wait_end;

   logic          pend_q;
   logic [31:0]   pend_ip_q;
   logic [47:0]   pend_mac_q;

   logic          busy_q, need_q;
   logic [31:0]   q_ip_q;
   logic [RW-1:0] retry_q;

   logic [15:0]   tx_oper_q;
   logic [31:0]   tx_ip_q;
   logic [47:0]   tx_mac_q;

   logic          done_q, fail_q;
   logic [47:0]   res_mac_q;

   logic          match, req_inflight, tmr_en, tmr_start, expire, retry_ok;

   // The local IP is framed by the ARP transmitter; scheduling never needs it.
   logic unused_local_ip;
   assign unused_local_ip = ^I_ip_local_addr;

   assign match        = busy_q & I_arp_reply_done & (I_arp_reply_ip_addr == q_ip_q);
   assign req_inflight = (state_q != TX_IDLE) & (tx_oper_q == ARP_REQUEST);
   assign tmr_en       = busy_q & ~need_q & ~req_inflight;
   assign tmr_start    = wait_end & (tx_oper_q == ARP_REQUEST) & busy_q & ~match;
   assign retry_ok     = retry_q < RW'(MAX_RETRY);

   uiarp_retry_timer #(.CYCLES(RETRY_CYCLES)) u_timer (
      .clk_i    (I_arp_clk),
      .rst_i    (I_arp_reset),
      .start_i  (tmr_start),
      .clear_i  (match),
      .enable_i (tmr_en),
      .expire_o (expire)
   );

   always_comb begin
      state_d    = state_q;
      take_reply = 1'b0;
      take_req   = 1'b0;
      wait_end   = 1'b0;
      unique case (state_q)
         TX_IDLE: begin
            if (pend_q) begin
               take_reply = 1'b1;
               state_d    = TX_CMD;
            end else if (need_q) begin
               take_req = 1'b1;
               state_d  = TX_CMD;
            end
         end
         TX_CMD:       if (I_tx_ready) state_d = TX_WAIT_DONE;
         TX_WAIT_DONE: if (I_tx_done) begin
            wait_end = 1'b1;
            state_d  = TX_IDLE;
         end
         default:      state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge I_arp_clk) begin
      if (I_arp_reset) begin
         state_q    <= TX_IDLE;
         pend_q     <= 1'b0;
         pend_ip_q  <= '0;
         pend_mac_q <= '0;
         busy_q     <= 1'b0;
         need_q     <= 1'b0;
         q_ip_q     <= '0;
         retry_q    <= '0;
         tx_oper_q  <= '0;
         tx_ip_q    <= '0;
         tx_mac_q   <= '0;
         done_q     <= 1'b0;
         fail_q     <= 1'b0;
         res_mac_q  <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= match;
         fail_q  <= 1'b0;
         if (match) res_mac_q <= I_arp_reply_mac_addr;

         // A newer peer request overwrites one not yet picked up.
         if (I_arp_req_valid) begin
            pend_q     <= 1'b1;
            pend_ip_q  <= I_arp_req_ip_addr;
            pend_mac_q <= I_arp_req_mac_addr;
         end else if (take_reply) begin
            pend_q <= 1'b0;
         end

         if (take_reply) begin
            tx_oper_q <= ARP_REPLY;
            tx_ip_q   <= pend_ip_q;
            tx_mac_q  <= pend_mac_q;
         end else if (take_req) begin
            tx_oper_q <= ARP_REQUEST;
            tx_ip_q   <= q_ip_q;
            tx_mac_q  <= '0;
         end

         if (!busy_q) begin
            if (I_resolve_req) begin
               busy_q  <= 1'b1;
               need_q  <= 1'b1;
               q_ip_q  <= I_resolve_ip_addr;
               retry_q <= '0;
            end
         end else if (match) begin
            busy_q <= 1'b0;
            need_q <= 1'b0;
         end else begin
            if (take_req) need_q <= 1'b0;
            if (expire) begin
               if (retry_ok) begin
                  retry_q <= retry_q + 1'b1;
                  need_q  <= 1'b1;
               end else begin
                  fail_q <= 1'b1;
                  busy_q <= 1'b0;
               end
            end
         end
      end
   end

   assign O_resolve_busy     = busy_q;
   assign O_resolve_done     = done_q;
   assign O_resolve_fail     = fail_q;
   assign O_resolve_mac_addr = res_mac_q;
   assign O_tx_valid         = (state_q == TX_CMD);
   assign O_tx_oper          = tx_oper_q;
   assign O_tx_ip_addr       = tx_ip_q;
   assign O_tx_mac_addr      = tx_mac_q;
endmodule
